// File: rtl/serial_magnitude_compare_pkg.sv
// serial_magnitude_compare_pkg: shared result codes, FSM states and ordering-decision encoding
package serial_magnitude_compare_pkg;
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;
  localparam logic [1:0] REL_EQ = 2'd0;
  localparam logic [1:0] REL_GT = 2'd1;
  localparam logic [1:0] REL_LT = 2'd2;
  // The first unequal nibble pair decides; later pairs cannot overturn it.
  function automatic logic [1:0] rel_step(input logic [1:0] cur, input logic gt, input logic lt);
    return cur != REL_EQ ? cur : gt ? REL_GT : lt ? REL_LT : REL_EQ;
  endfunction
  function automatic logic [2:0] rel_code(input logic [1:0] r, input logic [2:0] cascade);
    return r == REL_GT ? CMP_GT : r == REL_LT ? CMP_LT : cascade;
  endfunction
endpackage

// File: rtl/serial_magnitude_compare_nibble_rel.sv
// nibble_rel: combinational greater/less decision for one pair of 4-bit nibbles
module nibble_rel (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_gt,
  output logic       o_lt
);
  assign o_gt = i_a > i_b;
  assign o_lt = i_a < i_b;
endmodule

// File: rtl/serial_magnitude_compare.sv
// serial_magnitude_compare: MSB-first nibble-serial magnitude comparator with cascade pass-through
module serial_magnitude_compare
  import serial_magnitude_compare_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iValid,
  output logic       oReady,
  input  logic [3:0] iData_a,
  input  logic [3:0] iData_b,
  input  logic       iLast,
  input  logic [2:0] iData,
  output logic       oValid,
  input  logic       iAccept,
  output logic [2:0] oData,
  output logic       oErr
);
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(NIBBLES);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_rel;
  logic          r_valid;
  logic [2:0]    r_data;
  logic          r_err;
  logic          w_gt, w_lt, w_idle, w_acc, w_final, w_len_ok;
  logic [CW-1:0] w_beat;
  logic [1:0]    w_rel;
  nibble_rel u_rel (
    .i_a  (iData_a),
    .i_b  (iData_b),
    .o_gt (w_gt),
    .o_lt (w_lt)
  );
  // In IDLE the counter and decision are treated as freshly cleared for the incoming first beat.
  assign w_idle   = r_state == ST_IDLE;
  assign w_acc    = iValid && oReady;
  assign w_beat   = (w_idle ? '0 : r_cnt) + CW'(1);
  assign w_rel    = rel_step(w_idle ? REL_EQ : r_rel, w_gt, w_lt);
  assign w_final  = iLast || w_beat == LP_LAST;
  assign w_len_ok = iLast && w_beat == LP_LAST;
  assign oReady   = r_state != ST_HOLD;
  assign oValid   = r_valid;
  assign oData    = r_data;
  assign oErr     = r_err;
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rel   <= REL_EQ;
      r_valid <= 1'b0;
      r_data  <= 3'b000;
      r_err   <= 1'b0;
    end else if (w_acc && w_final) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_rel   <= REL_EQ;
      r_valid <= 1'b1;
      r_data  <= rel_code(w_rel, iData);
      r_err   <= !w_len_ok;
    end else if (w_acc) begin
      r_state <= ST_RUN;
      r_cnt   <= w_beat;
      r_rel   <= w_rel;
    end else if (r_state == ST_HOLD && iAccept) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_magnitude_compare.sv
// tb_serial_magnitude_compare: table, directed and random frames against a word-level reference
module tb_serial_magnitude_compare;
  logic       iClk = 1'b0, iRst_n = 1'b0, iValid = 1'b0, iLast = 1'b0, iAccept = 1'b0;
  logic [3:0] iData_a = '0, iData_b = '0;
  logic [2:0] iData = '0;
  logic       oReady, oValid, oErr;
  logic [2:0] oData;
  int n_tests = 0, n_fail = 0;

  serial_magnitude_compare #(.NIBBLES(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady),
    .iData_a(iData_a), .iData_b(iData_b), .iLast(iLast), .iData(iData),
    .oValid(oValid), .iAccept(iAccept), .oData(oData), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int k; logic [15:0] a; logic [15:0] b; bit last; logic [2:0] casc; logic [2:0] exp_d; bit exp_e;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Whole-word reference: the top k nibbles compared as unsigned integers.
  function automatic void model(input int k, input logic [15:0] a, input logic [15:0] b, input bit last,
                                input logic [2:0] casc, output logic [2:0] d, output bit e);
    int unsigned av, bv;
    av = a >> (16 - 4 * k);
    bv = b >> (16 - 4 * k);
    d = av > bv ? 3'b100 : av < bv ? 3'b010 : casc;
    e = !(last && k == 4);
  endfunction

  task automatic run_frame(input string name, input int k, input logic [15:0] a, input logic [15:0] b,
                           input bit last, input logic [2:0] casc, input logic [2:0] exp_d, input bit exp_e,
                           input int hold, input bit gaps);
    for (int i = 0; i < k; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
        iValid = 1'b0;
        @(negedge iClk);
      end
      chk({name, ".rdy"}, 16'(oReady), 16'd1);
      chk({name, ".early_vld"}, 16'(oValid), 16'd0);
      iValid  = 1'b1;
      iData_a = a[15-4*i -: 4];
      iData_b = b[15-4*i -: 4];
      iLast   = last && i == k - 1;
      iData   = (i == k - 1) ? casc : 3'($urandom);
      @(negedge iClk);
    end
    iValid = 1'b0;
    iLast  = 1'b0;
    chk({name, ".vld"}, 16'(oValid), 16'd1);
    chk({name, ".data"}, 16'(oData), 16'(exp_d));
    chk({name, ".err"}, 16'(oErr), 16'(exp_e));
    chk({name, ".hold_rdy"}, 16'(oReady), 16'd0);
    for (int h = 0; h < hold; h++) begin
      iValid  = 1'($urandom);
      iLast   = 1'($urandom);
      iData_a = 4'($urandom);
      iData_b = 4'($urandom);
      iData   = 3'($urandom);
      @(negedge iClk);
      chk({name, ".bp_vld"}, 16'(oValid), 16'd1);
      chk({name, ".bp_data"}, 16'(oData), 16'(exp_d));
      chk({name, ".bp_err"}, 16'(oErr), 16'(exp_e));
      chk({name, ".bp_rdy"}, 16'(oReady), 16'd0);
    end
    iValid  = 1'b0;
    iLast   = 1'b0;
    iAccept = 1'b1;
    @(negedge iClk);
    iAccept = 1'b0;
    chk({name, ".acc_vld"}, 16'(oValid), 16'd0);
    chk({name, ".acc_rdy"}, 16'(oReady), 16'd1);
    chk({name, ".kept_data"}, 16'(oData), 16'(exp_d));
  endtask

  initial begin
    vec_t tbl[$];
    logic [2:0] md;
    bit me;
    tbl.push_back('{4, 16'h1234, 16'h1235, 1, 3'b001, 3'b010, 0});
    tbl.push_back('{4, 16'h9000, 16'h8FFF, 1, 3'b001, 3'b100, 0});
    tbl.push_back('{4, 16'hABCD, 16'hABCD, 1, 3'b001, 3'b001, 0});
    tbl.push_back('{4, 16'hABCD, 16'hABCD, 1, 3'b100, 3'b100, 0});
    tbl.push_back('{4, 16'hABCD, 16'hABCD, 1, 3'b000, 3'b000, 0});
    tbl.push_back('{4, 16'hABCD, 16'hABCD, 1, 3'b110, 3'b110, 0});
    tbl.push_back('{2, 16'h1200, 16'h1200, 1, 3'b101, 3'b101, 1});
    tbl.push_back('{4, 16'h5555, 16'h5555, 0, 3'b111, 3'b111, 1});
    tbl.push_back('{1, 16'h3000, 16'h2000, 1, 3'b000, 3'b100, 1});
    tbl.push_back('{4, 16'h0000, 16'hFFFF, 1, 3'b011, 3'b010, 0});
    tbl.push_back('{4, 16'hFFFF, 16'h0000, 1, 3'b011, 3'b100, 0});

    repeat (2) @(negedge iClk);
    chk("reset.rdy", 16'(oReady), 16'd1);
    chk("reset.vld", 16'(oValid), 16'd0);
    chk("reset.data", 16'(oData), 16'd0);
    chk("reset.err", 16'(oErr), 16'd0);
    iRst_n = 1'b1;
    @(negedge iClk);

    foreach (tbl[i])
      run_frame($sformatf("tbl%0d", i), tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].last,
                tbl[i].casc, tbl[i].exp_d, tbl[i].exp_e, 0, 0);

    run_frame("backpressure", 4, 16'h4321, 16'h4320, 1, 3'b001, 3'b100, 0, 3, 0);

    // Abort a frame after two beats with an asynchronous reset between clock edges.
    for (int i = 0; i < 2; i++) begin
      iValid  = 1'b1;
      iData_a = 4'h7;
      iData_b = 4'h7;
      iLast   = 1'b0;
      @(negedge iClk);
    end
    iValid = 1'b0;
    #2 iRst_n = 1'b0;
    #1;
    chk("midrst.vld", 16'(oValid), 16'd0);
    chk("midrst.data", 16'(oData), 16'd0);
    chk("midrst.rdy", 16'(oReady), 16'd1);
    @(negedge iClk);
    iRst_n = 1'b1;
    run_frame("post_rst", 4, 16'h0001, 16'h0000, 1, 3'b001, 3'b100, 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      int k;
      bit last;
      logic [15:0] a, b;
      logic [2:0] casc;
      last = 1'($urandom);
      k    = last ? int'($urandom_range(1, 4)) : 4;
      a    = 16'($urandom);
      case ($urandom_range(0, 2))
        0: b = a;
        1: b = a ^ (16'h1 << $urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      casc = 3'($urandom);
      model(k, a, b, last, casc, md, me);
      run_frame($sformatf("rnd%0d", r), k, a, b, last, casc, md, me, $urandom_range(0, 2), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
